// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory, lowest beat first.
// Optional watchdog abort when built with ADAPTOR_TIMEOUT_EN (adds timeout_o).
module cacheline_adaptor #(
   parameter int LINE_W      = 256,
   parameter int BURST_W     = 64,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
`ifdef ADAPTOR_TIMEOUT_EN
   ,
   output logic               timeout_o
`endif
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   generate
      if ((LINE_W % BURST_W) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
         $error("cacheline_adaptor: LINE_W must be a multiple of BURST_W and TIMEOUT_CYC >= 1");
      end
   endgenerate

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [LINE_W-1:0] r_line;
   logic [LINE_W-1:0] r_buf;
   logic [31:0]       r_addr;
   logic              w_last;

   assign w_last    = (r_cnt == CNT_W'(BEATS - 1));
   assign line_o    = r_line;
   assign address_o = r_addr;
   assign read_o    = (r_state == S_RD);
   assign write_o   = (r_state == S_WR);
   assign resp_o    = (r_state == S_DONE);
   assign burst_o   = r_buf[r_cnt*BURST_W +: BURST_W];

`ifdef ADAPTOR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] r_idle;
   logic            r_timeout;
   assign timeout_o = r_timeout;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_line  <= '0;
         r_buf   <= '0;
         r_addr  <= '0;
`ifdef ADAPTOR_TIMEOUT_EN
         r_idle    <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
`ifdef ADAPTOR_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               // Read has priority; a concurrent write is simply not taken.
               if (read_i || write_i) begin
                  r_state <= read_i ? S_RD : S_WR;
                  r_addr  <= address_i & 32'hFFFF_FFE0;
                  r_cnt   <= '0;
`ifdef ADAPTOR_TIMEOUT_EN
                  r_idle  <= '0;
`endif
                  if (!read_i) begin
                     r_buf <= line_i;
                  end
               end
            end
            S_RD, S_WR: begin
               if (resp_i) begin
                  if (r_state == S_RD) begin
                     r_line[r_cnt*BURST_W +: BURST_W] <= burst_i;
                  end
                  r_cnt <= r_cnt + CNT_W'(1);
`ifdef ADAPTOR_TIMEOUT_EN
                  r_idle <= '0;
`endif
                  if (w_last) begin
                     r_state <= S_DONE;
                  end
               end
`ifdef ADAPTOR_TIMEOUT_EN
               // Abort after TIMEOUT_CYC beat-less cycles; captured data is kept.
               else if (r_idle == TO_W'(TIMEOUT_CYC - 1)) begin
                  r_state   <= S_IDLE;
                  r_timeout <= 1'b1;
                  r_idle    <= '0;
               end else begin
                  r_idle <= r_idle + TO_W'(1);
               end
`endif
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed table, hand sequences, random transactions.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int errors = 0;
   int checks = 0;
   logic [255:0] last_line;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           rd;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wline;
      logic [255:0] beats;
      logic [15:0]  pat;
      int           plen;
      logic [31:0]  exp_addr;
      logic [255:0] exp_line;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drives one cache request and plays the memory side; plen==0 means random strobes.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] beats,
                          input logic [15:0] pat, input int plen,
                          input logic [31:0] exp_addr, input logic [255:0] exp_line,
                          input string tag);
      int  beat = 0;
      int  idx  = 0;
      int  cyc  = 0;
      bit  strobe;
      bit  is_wr = wr && !rd;
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = wline;
      resp_i    = 1'b0;
      tick();
      while (beat < 4 && cyc < 200) begin
         chk({tag, " ctl"}, {253'd0, read_o, write_o, resp_o}, {253'd0, rd, is_wr, 1'b0});
         if (is_wr) chk({tag, " burst"}, burst_o, wline[64*beat +: 64]);
         strobe = (plen > 0) ? pat[idx % plen] : ($urandom_range(0, 2) != 0);
         idx++;
         if (strobe) begin
            resp_i  = 1'b1;
            burst_i = beats[64*beat +: 64];
            beat++;
         end else begin
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
         end
         tick();
         cyc++;
      end
      chk({tag, " beats_done"}, beat, 4);
      // DONE cycle: stray strobes must be ignored.
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      chk({tag, " resp"}, {253'd0, read_o, write_o, resp_o}, 256'd1);
      chk({tag, " addr"}, address_o, exp_addr);
      tick();
      read_i  = 1'b0;
      write_i = 1'b0;
      burst_i = {$urandom, $urandom};
      chk({tag, " after_resp"}, {253'd0, read_o, write_o, resp_o}, 256'd0);
      tick();
      resp_i = 1'b0;
      chk({tag, " idle"}, {253'd0, read_o, write_o, resp_o}, 256'd0);
      chk({tag, " line"}, line_o, exp_line);
   endtask

   initial begin
      logic [255:0] rb;
      logic [255:0] wl;
      logic [255:0] exp;
      logic [63:0]  b [4];
      logic [31:0]  a;
      bit           rd;
      bit           wr;

      vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'd0,
                  256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                  16'h000F, 4, 32'h0000_1220,
                  256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_ABFF,
                  256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA,
                  256'h0, 16'h0059, 7, 32'h0000_ABE0,
                  256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
      vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 256'hEEEE,
                  256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0,
                  16'h0006, 4, 32'hFFFF_FFE0,
                  256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0};
      vecs[3] = '{1'b0, 1'b1, 32'h8000_001F,
                  256'hCAFEF00DCAFEF00D_0000000000000001_8000000000000000_5A5A5A5AA5A5A5A5,
                  256'h0, 16'h8001, 16, 32'h8000_0000,
                  256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0};

      rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      address_i = '0; line_i = '0; burst_i = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst line_o", line_o, 256'd0);
      chk("rst address_o", address_o, 256'd0);
      chk("rst burst_o", burst_o, 256'd0);
      chk("rst ctl", {253'd0, read_o, write_o, resp_o}, 256'd0);
      for (int i = 0; i < 10; i++) begin
         resp_i  = $urandom_range(0, 1);
         burst_i = {$urandom, $urandom};
         tick();
         chk("idle ctl", {253'd0, read_o, write_o, resp_o}, 256'd0);
      end
      resp_i = 1'b0;
      chk("idle line_o", line_o, 256'd0);

      for (int i = 0; i < 4; i++) begin
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wline, vecs[i].beats,
                 vecs[i].pat, vecs[i].plen, vecs[i].exp_addr, vecs[i].exp_line,
                 $sformatf("vec%0d", i));
      end

      // Reset two beats into a read.
      read_i = 1'b1; address_i = 32'h0000_0040;
      tick();
      resp_i = 1'b1; burst_i = 64'h1234_5678_9ABC_DEF0;
      tick();
      burst_i = 64'h0FED_CBA9_8765_4321;
      tick();
      rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst ctl", {253'd0, read_o, write_o, resp_o}, 256'd0);
      chk("midrst line_o", line_o, 256'd0);
      tick();
      chk("midrst no_resp", {253'd0, read_o, write_o, resp_o}, 256'd0);
      run_txn(vecs[0].rd, vecs[0].wr, vecs[0].addr, vecs[0].wline, vecs[0].beats,
              vecs[0].pat, vecs[0].plen, vecs[0].exp_addr, vecs[0].exp_line, "post_rst");
      last_line = vecs[0].exp_line;

      for (int t = 0; t < 24; t++) begin
         rd = $urandom_range(0, 1);
         wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
         a  = $urandom;
         for (int w = 0; w < 8; w++) wl[32*w +: 32] = $urandom;
         for (int k = 0; k < 4; k++) b[k] = {$urandom, $urandom};
         rb = '0;
         for (int k = 0; k < 4; k++) rb = rb | ({192'd0, b[k]} << (64 * k));
         exp = rd ? rb : last_line;
         run_txn(rd, wr, a, wl, rb, 16'h0, 0, {a[31:5], 5'b00000}, exp,
                 $sformatf("rnd%0d", t));
         last_line = exp;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
